// File: rtl/dmem_lsu.sv
// dmem_lsu: single-outstanding load/store initiator; sub-word stores are read-modify-write on a full-word memory port.
module dmem_lsu #(
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_we,
    output logic [3:0]        mem_amp,
    output logic [31:0]       mem_wd,
    input  logic [31:0]       mem_rd
);
    typedef enum logic [2:0] {IDLE, LOAD, MERGE, STORE, RESP} state_t;
    state_t state;
    logic [ADDR_W+1:0] addr;
    logic [1:0] size;
    logic uns, err, unused_addr;
    logic [15:0] wdata, lane;
    logic [4:0] sh;
    logic [31:0] ext, mask, merged;

    assign unused_addr = ^req_addr[31:ADDR_W+2];
    assign req_ready = state == IDLE;
    assign mem_we = state == STORE;
    assign mem_amp = 4'b1111;
    assign mem_a = addr[ADDR_W+1:2];
    assign err = req_size == 2'b11 || (req_size == 2'b01 && req_addr[0]) ||
                 (req_size == 2'b10 && req_addr[1:0] != 2'b00);

    // Lane shift is shared by load extraction and store merge.
    always_comb begin
        sh = size == 2'b00 ? {addr[1:0], 3'b000} : {addr[1], 4'b0000};
        lane = 16'(mem_rd >> sh);
        ext = size == 2'b00 ? {{24{~uns & lane[7]}}, lane[7:0]} :
              size == 2'b01 ? {{16{~uns & lane[15]}}, lane} : mem_rd;
        mask = size == 2'b00 ? 32'h0000_00FF << sh : 32'h0000_FFFF << sh;
        merged = (mem_rd & ~mask) | (({16'h0000, wdata}) << sh & mask);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            addr <= '0;
            size <= '0;
            uns <= 1'b0;
            wdata <= '0;
            mem_wd <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    addr <= req_addr[ADDR_W+1:0];
                    size <= req_size;
                    uns <= req_unsigned;
                    wdata <= req_wdata[15:0];
                    resp_err <= err;
                    resp_valid <= err;
                    if (req_we && req_size == 2'b10 && !err) mem_wd <= req_wdata;
                    state <= err ? RESP : !req_we ? LOAD : req_size == 2'b10 ? STORE : MERGE;
                end
                LOAD: begin
                    resp_rdata <= ext;
                    resp_valid <= 1'b1;
                    state <= RESP;
                end
                MERGE: begin
                    mem_wd <= merged;
                    state <= STORE;
                end
                STORE: begin
                    resp_valid <= 1'b1;
                    state <= RESP;
                end
                RESP: if (resp_ready) begin
                    resp_valid <= 1'b0;
                    resp_rdata <= '0;
                    resp_err <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: randomized scoreboard bench for dmem_lsu against a byte-array reference model.
module tb_dmem_lsu;
    localparam int AW = 7;
    logic clk = 1'b0, rst_n = 1'b1;
    logic req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0, resp_ready = 1'b1;
    logic [1:0] req_size = '0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic req_ready, resp_valid, resp_err, mem_we;
    logic [31:0] resp_rdata, mem_wd, mem_rd;
    logic [AW-1:0] mem_a;
    logic [3:0] mem_amp;

    logic [31:0] mem [128];
    logic [7:0] rb [512];
    logic [32:0] rq [$];
    logic [38:0] wq [$];
    int checks = 0, passes = 0, rr_mode = 0;
    logic [31:0] last_rdata = '0;
    logic last_err = 1'b0;
    logic [31:0] t2_addr [4] = '{32'h15, 32'h16, 32'h16, 32'h16};
    logic [1:0] t2_size [4] = '{2'd0, 2'd0, 2'd1, 2'd1};
    logic t2_uns [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] t2_exp [4] = '{32'h0000007F, 32'hFFFFFFFF, 32'h000080FF, 32'hFFFF80FF};

    dmem_lsu #(.ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_a(mem_a), .mem_we(mem_we), .mem_amp(mem_amp), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;
    assign mem_rd = mem[mem_a];
    always @(posedge clk) if (mem_we) mem[mem_a] = mem_wd;
    always @(posedge clk) begin
        #2;
        resp_ready = rr_mode == 0 ? 1'b1 : rr_mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic poke(input int i, input logic [31:0] v);
        mem[i] = v;
        for (int k = 0; k < 4; k++) rb[4*i+k] = v[8*k +: 8];
    endtask

    // Reference: memory as 512 bytes, little-endian, address wraps at 512.
    task automatic model_req(input bit we, input logic [1:0] size, input bit uns,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             output logic [32:0] resp, output bit wr, output logic [38:0] wexp);
        int a, n, wi;
        logic [31:0] v;
        bit err;
        a = int'(addr & 32'h1FF);
        n = 1 << size;
        err = size == 2'd3 || (a % n) != 0;
        wr = 1'b0;
        wexp = '0;
        v = '0;
        if (!err && we) begin
            for (int i = 0; i < n; i++) rb[a+i] = wdata[8*i +: 8];
            wi = a / 4;
            wr = 1'b1;
            wexp = {7'(wi), rb[4*wi+3], rb[4*wi+2], rb[4*wi+1], rb[4*wi]};
        end else if (!err) begin
            for (int i = 0; i < n; i++) v[8*i +: 8] = rb[a+i];
            if (!uns && v[8*n-1]) for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
        end
        resp = {err, v};
    endtask

    task automatic send(input bit we, input logic [1:0] size, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
        logic [32:0] resp;
        logic [38:0] wexp;
        bit wr;
        int n, exp_lat;
        n = 0;
        while (!req_ready && n < 100) begin @(posedge clk); #1; n++; end
        if (!req_ready) begin
            $display("FAIL accept_timeout: req_ready stuck low");
            $fatal(1);
        end
        model_req(we, size, uns, addr, wdata, resp, wr, wexp);
        rq.push_back(resp);
        if (wr) wq.push_back(wexp);
        req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        exp_lat = resp[32] ? 1 : !we ? 2 : size == 2'd2 ? 2 : 3;
        n = 1;
        while (!resp_valid && n < 20) begin @(posedge clk); #1; n++; end
        check("latency", 64'(n), 64'(exp_lat));
    endtask

    always @(negedge clk) begin
        if (rst_n && resp_valid && resp_ready) begin
            if (rq.size() == 0) begin
                checks++;
                $display("FAIL resp_unexpected: got err=%0b rdata=%h with nothing pending", resp_err, resp_rdata);
            end else check("resp", {31'd0, resp_err, resp_rdata}, {31'd0, rq.pop_front()});
            last_rdata = resp_rdata;
            last_err = resp_err;
        end
        if (rst_n && mem_we) begin
            if (wq.size() == 0) begin
                checks++;
                $display("FAIL write_unexpected: got a=%0d wd=%h with no write pending", mem_a, mem_wd);
            end else check("write", {25'd0, mem_a, mem_wd}, {25'd0, wq.pop_front()});
            check("mem_amp", 64'(mem_amp), 64'hF);
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] w2, w4, held;
        int n;
        for (int i = 0; i < 128; i++) poke(i, $urandom);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_rdata", 64'(resp_rdata), 64'd0);
        check("rst_resp_err", 64'(resp_err), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_mem_wd", 64'(mem_wd), 64'd0);
        check("rst_mem_a", 64'(mem_a), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        poke(5, 32'h11223344);
        send(1'b1, 2'd0, 1'b0, 32'h16, 32'hAB);
        check("t1_mem5", 64'(mem[5]), 64'h11AB3344);
        @(posedge clk); #1;
        check("t1_single_cycle_valid", 64'(resp_valid), 64'd0);
        check("t1_err", 64'(last_err), 64'd0);

        poke(5, 32'h80FF7F01);
        for (int i = 0; i < 4; i++) begin
            send(1'b0, t2_size[i], t2_uns[i], t2_addr[i], 32'h0);
            @(posedge clk); #1;
            check("t2_load", 64'(last_rdata), 64'(t2_exp[i]));
        end

        send(1'b1, 2'd2, 1'b0, 32'h20C, 32'hDEADBEEF);
        check("t3_mem3", 64'(mem[3]), 64'hDEADBEEF);

        w2 = mem[2]; w4 = mem[4];
        send(1'b1, 2'd1, 1'b0, 32'h13, 32'h1234);
        @(posedge clk); #1;
        check("t4_half_err", 64'(last_err), 64'd1);
        send(1'b0, 2'd2, 1'b0, 32'h0A, 32'h0);
        @(posedge clk); #1;
        check("t4_word_err", 64'(last_err), 64'd1);
        check("t4_rdata", 64'(last_rdata), 64'd0);
        check("t4_mem4", 64'(mem[4]), 64'(w4));
        check("t4_mem2", 64'(mem[2]), 64'(w2));

        rr_mode = 2;
        @(posedge clk); #1;
        send(1'b0, 2'd2, 1'b0, 32'h14, 32'h0);
        held = resp_rdata;
        check("t5_rdata", 64'(held), 64'h80FF7F01);
        repeat (5) begin
            @(posedge clk); #1;
            check("t5_valid_held", 64'(resp_valid), 64'd1);
            check("t5_rdata_held", 64'(resp_rdata), 64'(held));
            check("t5_req_ready_low", 64'(req_ready), 64'd0);
        end
        rr_mode = 0;
        send(1'b0, 2'd0, 1'b1, 32'h17, 32'h0);

        n = 0;
        while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
        poke(8, 32'hCAFEF00D);
        req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0; req_addr = 32'h21; req_wdata = 32'h55;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("t6_in_store", 64'(mem_we), 64'd1);
        #1 rst_n = 1'b0;
        #1 check("t6_we_drop", 64'(mem_we), 64'd0);
        @(posedge clk); #1;
        check("t6_mem8", 64'(mem[8]), 64'hCAFEF00D);
        rst_n = 1'b1;
        #1;
        check("t6_resp_valid", 64'(resp_valid), 64'd0);
        check("t6_req_ready", 64'(req_ready), 64'd1);
        @(posedge clk); #1;

        rr_mode = 1;
        repeat (300)
            send(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 $urandom, $urandom);
        rr_mode = 0;
        n = 0;
        while ((rq.size() != 0 || wq.size() != 0) && n < 50) begin @(posedge clk); #1; n++; end
        check("drain_resp", 64'(rq.size()), 64'd0);
        check("drain_write", 64'(wq.size()), 64'd0);
        for (int i = 0; i < 128; i++)
            check("final_mem", 64'(mem[i]), 64'({rb[4*i+3], rb[4*i+2], rb[4*i+1], rb[4*i]}));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
